common_lru_victim_alloc: RTL

Victim allocator for set-associative structures that use the pseudo-LRU swap tracker with binary output. It consumes the tracker's binary victim index and accepts one miss at a time. It hands the latched victim way to the refill engine through a valid/ready handshake, then issues the one-hot touch back to the tracker when refill completes. Hit notifications are also converted into registered one-hot touches, so this block is the tracker's only writer.

---
 rtl/common_lru_pkg.sv | 10 +
 rtl/macro_decoder_bin_onehot.sv | 14 +
 rtl/common_lru_victim_alloc.sv | 94 +++++++++
 3 files changed

// File: rtl/common_lru_pkg.sv
// Shared definitions for the pseudo-LRU victim allocator: FSM encoding and default sizing.
package common_lru_pkg;

    localparam int unsigned WAY_COUNT_LOG2_DEFAULT = 2;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_FILL = 2'd2;

endpackage

// File: rtl/macro_decoder_bin_onehot.sv
// Binary to one-hot decoder.
module macro_decoder_bin_onehot #(
    parameter int unsigned INPUT_WIDTH = 2
) (
    input  logic [INPUT_WIDTH-1:0]      bin,
    output logic [(1<<INPUT_WIDTH)-1:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[bin] = 1'b1;
    end

endmodule

// File: rtl/common_lru_victim_alloc.sv
// Victim allocator: latches the tracker's victim on a miss, hands it to the refill engine,
// and is the sole writer of one-hot touches (fill completions and hits) back to the tracker.
module common_lru_victim_alloc
    import common_lru_pkg::*;
#(
    parameter int unsigned WAY_COUNT_LOG2 = WAY_COUNT_LOG2_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hit_valid,
    input  logic [WAY_COUNT_LOG2-1:0]    hit_way,
    input  logic                         miss_valid,
    output logic                         miss_ready,
    output logic                         refill_valid,
    output logic [WAY_COUNT_LOG2-1:0]    refill_way,
    input  logic                         refill_ready,
    input  logic                         refill_done,
    input  logic [WAY_COUNT_LOG2-1:0]    lru_qaddr,
    output logic [(1<<WAY_COUNT_LOG2)-1:0] lru_waddr,
    output logic                         lru_wen,
    output logic                         busy
);

    localparam int unsigned WAYS = 1 << WAY_COUNT_LOG2;

    logic [1:0]                state_q, state_d;
    logic [WAY_COUNT_LOG2-1:0] victim_q, victim_d;
    logic                      miss_ready_q, miss_ready_d;
    logic                      wen_q;
    logic [WAYS-1:0]           waddr_q, waddr_d;
    logic                      fill_touch, touch;
    logic [WAY_COUNT_LOG2-1:0] touch_idx;
    logic [WAYS-1:0]           touch_onehot;

    // A completed fill takes priority over a same-cycle hit touch.
    assign fill_touch = (state_q == WAIT_FILL) && refill_done;
    assign touch      = fill_touch || hit_valid;
    assign touch_idx  = fill_touch ? victim_q : hit_way;

    macro_decoder_bin_onehot #(
        .INPUT_WIDTH (WAY_COUNT_LOG2)
    ) u_touch_dec (
        .bin    (touch_idx),
        .onehot (touch_onehot)
    );

    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        case (state_q)
            IDLE: begin
                if (miss_valid && miss_ready_q) begin
                    state_d  = ISSUE;
                    victim_d = lru_qaddr;
                end
            end
            ISSUE: begin
                if (refill_ready) state_d = WAIT_FILL;
            end
            WAIT_FILL: begin
                if (refill_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold off misses while a touch lands so lru_qaddr is up to date when sampled.
    assign miss_ready_d = (state_d == IDLE) && !touch;
    assign waddr_d      = touch ? touch_onehot : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            miss_ready_q <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            miss_ready_q <= miss_ready_d;
            wen_q        <= touch;
            waddr_q      <= waddr_d;
        end
    end

    assign miss_ready   = miss_ready_q;
    assign refill_valid = (state_q == ISSUE);
    assign refill_way   = victim_q;
    assign lru_wen      = wen_q;
    assign lru_waddr    = waddr_q;
    assign busy         = (state_q != IDLE);

endmodule
